mips_dmem_mmio: RTL and testbench

//  Data-side responder for the MIPS core's memory port.
//  - Accepts memwrite/memaddr/memwritedata from the core's MEM stage.
//  - Returns memreaddata in the same cycle, so the core can capture it into its MEM/WB register at the next edge.
//  - Contains word-addressed data RAM plus a memory-mapped timer (with compare and IRQ) and a GPIO block.
//  - Sits between the CPU core and the system top, in place of a bare data memory.

---
 rtl/mips_dmem_mmio.sv | 133 +++++++++++++
 tb/tb_mips_dmem_mmio.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_mmio.sv
// Data-side memory responder for the MIPS core: word RAM plus a small register page
// holding a compare timer with interrupt and a GPIO block. Reads are combinational.
module mips_dmem_mmio #(
   parameter int          RAM_AW    = 10,
   parameter int          GPIO_W    = 8,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [31:0]       memaddr,
   input  logic [31:0]       memwritedata,
   output logic [31:0]       memreaddata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_COUNT    = 3'd1;
   localparam logic [2:0] OFF_CMP      = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_GPIO_OUT = 3'd4;
   localparam logic [2:0] OFF_GPIO_IN  = 3'd5;

   logic [31:0]       ramMem [0:(1<<RAM_AW)-1];
   logic [2:0]        ctrl_q, ctrl_d;
   logic [31:0]       count_q, count_d;
   logic [31:0]       cmp_q, cmp_d;
   logic              match_q, match_d;
   logic [GPIO_W-1:0] gpioOut_q, gpioOut_d;
   logic [GPIO_W-1:0] gpioSync1_q, gpioSync2_q;

   logic              ramSel, regSel, ramWe, timerHit;
   logic              wrCtrl, wrCount, wrCmp, wrStatus, wrGpioOut;
   logic [2:0]        regOff;
   logic [RAM_AW-1:0] ramIdx;
   logic              unusedAddrBits;

   assign ramSel         = (memaddr[31:RAM_AW+2] == '0);
   assign regSel         = (memaddr[31:5] == MMIO_BASE[31:5]);
   assign regOff         = memaddr[4:2];
   assign ramIdx         = memaddr[RAM_AW+1:2];
   assign unusedAddrBits = ^memaddr[1:0];

   assign wrCtrl    = memwrite && regSel && (regOff == OFF_CTRL);
   assign wrCount   = memwrite && regSel && (regOff == OFF_COUNT);
   assign wrCmp     = memwrite && regSel && (regOff == OFF_CMP);
   assign wrStatus  = memwrite && regSel && (regOff == OFF_STATUS);
   assign wrGpioOut = memwrite && regSel && (regOff == OFF_GPIO_OUT);

   // RAM has no reset; the write enable is qualified so writes during reset are dropped
   assign ramWe = memwrite && ramSel && reset;

   always_ff @(posedge clk) begin
      if (ramWe) begin
         ramMem[ramIdx] <= memwritedata;
      end
   end

   // Compare uses pre-write CTRL/COUNT/CMP, so a write in the match cycle cannot mask it
   always_comb begin
      timerHit  = ctrl_q[0] && (count_q == cmp_q);
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      match_d   = match_q;
      gpioOut_d = gpioOut_q;

      if (ctrl_q[0]) begin
         count_d = (timerHit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
      end
      if (wrCount) begin
         count_d = memwritedata;
      end
      if (wrStatus && memwritedata[0]) begin
         match_d = 1'b0;
      end
      if (timerHit) begin
         match_d = 1'b1;
      end
      if (wrCtrl) begin
         ctrl_d = memwritedata[2:0];
      end
      if (wrCmp) begin
         cmp_d = memwritedata;
      end
      if (wrGpioOut) begin
         gpioOut_d = memwritedata[GPIO_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q      <= '0;
         count_q     <= '0;
         cmp_q       <= '0;
         match_q     <= 1'b0;
         gpioOut_q   <= '0;
         gpioSync1_q <= '0;
         gpioSync2_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         count_q     <= count_d;
         cmp_q       <= cmp_d;
         match_q     <= match_d;
         gpioOut_q   <= gpioOut_d;
         gpioSync1_q <= gpio_in;
         gpioSync2_q <= gpioSync1_q;
      end
   end

   always_comb begin
      memreaddata = 32'd0;
      if (ramSel) begin
         memreaddata = ramMem[ramIdx];
      end else if (regSel) begin
         case (regOff)
            OFF_CTRL:     memreaddata = {29'd0, ctrl_q};
            OFF_COUNT:    memreaddata = count_q;
            OFF_CMP:      memreaddata = cmp_q;
            OFF_STATUS:   memreaddata = {31'd0, match_q};
            OFF_GPIO_OUT: memreaddata = {{(32-GPIO_W){1'b0}}, gpioOut_q};
            OFF_GPIO_IN:  memreaddata = {{(32-GPIO_W){1'b0}}, gpioSync2_q};
            default:      memreaddata = 32'd0;
         endcase
      end
   end

   assign gpio_out  = gpioOut_q;
   assign timer_irq = match_q && ctrl_q[2];

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed scenarios plus randomized traffic,
// all compared against a behavioural model of RAM, timer and GPIO kept here.
module tb_mips_dmem_mmio;

   localparam logic [31:0] A_CTRL     = 32'hFFFF_0000;
   localparam logic [31:0] A_COUNT    = 32'hFFFF_0004;
   localparam logic [31:0] A_CMP      = 32'hFFFF_0008;
   localparam logic [31:0] A_STATUS   = 32'hFFFF_000C;
   localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0010;
   localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0014;
   localparam logic [31:0] A_RSVD     = 32'hFFFF_0018;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] memaddr = 32'd0;
   logic [31:0] memwritedata = 32'd0;
   logic [31:0] memreaddata;
   logic [7:0]  gpio_in = 8'd0;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [2:0]  mCtrl;
   logic [31:0] mCount, mCmp;
   logic        mMatch;
   logic [7:0]  mGpioOut, mSync1, mSync2;
   logic [31:0] ramModel [int];

   mips_dmem_mmio dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .memreaddata  (memreaddata),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .timer_irq    (timer_irq)
   );

   always #10 clk = ~clk;

   function automatic bit isRam(input logic [31:0] a);
      return a[31:12] == 20'd0;
   endfunction

   function automatic bit isReg(input logic [31:0] a);
      return (a >> 5) == (32'hFFFF_0000 >> 5);
   endfunction

   function automatic bit modelKnown(input logic [31:0] a);
      if (isRam(a)) return ramModel.exists(int'(a[11:2]));
      return 1'b1;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (isRam(a)) return ramModel.exists(int'(a[11:2])) ? ramModel[int'(a[11:2])] : 32'd0;
      if (!isReg(a)) return 32'd0;
      case ((a - 32'hFFFF_0000) >> 2)
         0:       return {29'd0, mCtrl};
         1:       return mCount;
         2:       return mCmp;
         3:       return {31'd0, mMatch};
         4:       return {24'd0, mGpioOut};
         5:       return {24'd0, mSync2};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic modelIrq();
      return mMatch & mCtrl[2];
   endfunction

   task automatic modelReset();
      mCtrl = 3'd0; mCount = 32'd0; mCmp = 32'd0; mMatch = 1'b0;
      mGpioOut = 8'd0; mSync1 = 8'd0; mSync2 = 8'd0;
   endtask

   // One rising edge of the specified behaviour: timer decision from pre-edge state,
   // then the CPU write (which wins for COUNT, loses to a match for STATUS).
   task automatic modelEdge(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] gin);
      logic        hit;
      logic [31:0] newCount;
      logic        newMatch;
      if (!reset) return;
      hit      = mCtrl[0] && (mCount == mCmp);
      newCount = mCount;
      if (mCtrl[0]) newCount = (hit && mCtrl[1]) ? 32'd0 : mCount + 32'd1;
      newMatch = mMatch;
      if (we && a == A_STATUS && d[0]) newMatch = 1'b0;
      if (hit) newMatch = 1'b1;
      mSync2 = mSync1;
      mSync1 = gin;
      if (we && isRam(a)) ramModel[int'(a[11:2])] = d;
      if (we && isReg(a)) begin
         case ((a - 32'hFFFF_0000) >> 2)
            0: mCtrl = d[2:0];
            1: newCount = d;
            2: mCmp = d;
            4: mGpioOut = d[7:0];
            default: ;
         endcase
      end
      mCount = newCount;
      mMatch = newMatch;
   endtask

   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
      memwrite = we; memaddr = a; memwritedata = d;
      @(posedge clk);
      modelEdge(we, a, d, gpio_in);
      #1;
      memwrite = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d);
      memwrite = 1'b0;
      memaddr  = a;
      #1;
      d = memreaddata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      modelReset();
      step(1'b0, 32'd0, 32'd0);
      step(1'b1, A_COUNT, 32'd77);
      step(1'b1, A_CTRL, 32'd7);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_count_write_ignored: got %h expected %h", rd, 32'd0); end
      busRead(A_CTRL, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected %h", rd, 32'd0); end
      busRead(A_STATUS, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", rd, 32'd0); end
      checks++;
      if (gpio_out !== 8'd0 || timer_irq !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_pins: got gpio_out=%h irq=%b expected 00/0", gpio_out, timer_irq);
      end
      #2 reset = 1'b1;
   endtask

   task automatic test_ram();
      logic [31:0] rd;
      step(1'b1, 32'h0000_0014, 32'h1234_5678);
      step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      busRead(32'h0000_0010, rd);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_read_10: got %h expected %h", rd, 32'hDEAD_BEEF); end
      busRead(32'h0000_0013, rd);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_read_13: got %h expected %h", rd, 32'hDEAD_BEEF); end
      busRead(32'h0000_0014, rd);
      checks++;
      if (rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ram_neighbour_14: got %h expected %h", rd, 32'h1234_5678); end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = 32'h0000_0100 + 32'(i * 4) + 32'($urandom_range(0, 3));
         d = $urandom;
         step(1'b1, a, d);
         busRead(a, rd);
         checks++;
         if (rd !== modelRead(a)) begin errors++; $display("[TB] FAIL ram_random @%h: got %h expected %h", a, rd, modelRead(a)); end
      end
      busRead(32'h0000_0FFC, rd);
      step(1'b1, 32'h0000_0FFC, 32'hCAFE_0001);
      busRead(32'h0000_0FFC, rd);
      checks++;
      if (rd !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL ram_top_word: got %h expected %h", rd, 32'hCAFE_0001); end
   endtask

   task automatic test_timer_autoreload();
      logic [31:0] rd, st;
      int seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
      step(1'b1, A_CTRL, 32'd0);
      step(1'b1, A_STATUS, 32'd1);
      step(1'b1, A_CMP, 32'd3);
      step(1'b1, A_COUNT, 32'd0);
      step(1'b1, A_CTRL, 32'b011);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 32'h0000_0000, 32'd0);
         busRead(A_COUNT, rd);
         checks++;
         if (rd !== 32'(seq[i]) || rd !== mCount) begin
            errors++; $display("[TB] FAIL autoreload_count[%0d]: got %0d expected %0d", i, rd, seq[i]);
         end
         busRead(A_STATUS, st);
         checks++;
         if (st !== (i >= 3 ? 32'd1 : 32'd0) || timer_irq !== 1'b0) begin
            errors++; $display("[TB] FAIL autoreload_status[%0d]: got status=%h irq=%b expected %h/0", i, st, timer_irq, (i >= 3 ? 1 : 0));
         end
      end
   endtask

   task automatic test_irq_w1c();
      logic [31:0] rd;
      bit seen;
      step(1'b1, A_CTRL, 32'd0);
      step(1'b1, A_STATUS, 32'd1);
      step(1'b1, A_COUNT, 32'd0);
      step(1'b1, A_CMP, 32'd5);
      step(1'b1, A_CTRL, 32'b101);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, 32'h0000_0000, 32'd0);
         checks++;
         if (timer_irq !== modelIrq()) begin
            errors++; $display("[TB] FAIL irq_rise[%0d]: got %b expected %b", i, timer_irq, modelIrq());
         end
         seen = modelIrq();
      end
      busRead(A_COUNT, rd);
      checks++;
      if (!seen || timer_irq !== 1'b1 || rd !== 32'd6) begin
         errors++; $display("[TB] FAIL irq_after_match: got irq=%b count=%0d expected 1/6", timer_irq, rd);
      end
      step(1'b1, A_STATUS, 32'd1);
      busRead(A_STATUS, rd);
      checks++;
      if (timer_irq !== 1'b0 || rd !== 32'd0) begin
         errors++; $display("[TB] FAIL irq_w1c_clear: got irq=%b status=%h expected 0/0", timer_irq, rd);
      end
      step(1'b1, A_COUNT, 32'd4);
      step(1'b0, 32'h0000_0000, 32'd0);
      step(1'b1, A_STATUS, 32'd1);
      busRead(A_STATUS, rd);
      checks++;
      if (timer_irq !== 1'b1 || rd !== 32'd1) begin
         errors++; $display("[TB] FAIL irq_match_beats_w1c: got irq=%b status=%h expected 1/1", timer_irq, rd);
      end
   endtask

   task automatic test_wrap_priority();
      logic [31:0] rd;
      step(1'b1, A_CTRL, 32'd0);
      step(1'b1, A_STATUS, 32'd1);
      step(1'b1, A_CMP, 32'd1000);
      step(1'b1, A_COUNT, 32'hFFFF_FFFF);
      step(1'b1, A_CTRL, 32'd1);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_hold_before_en: got %h expected %h", rd, 32'hFFFF_FFFF); end
      step(1'b0, 32'h0000_0000, 32'd0);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd0 || rd !== mCount) begin errors++; $display("[TB] FAIL wrap_to_zero: got %h expected %h", rd, 32'd0); end
      step(1'b1, A_COUNT, 32'd100);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd100) begin errors++; $display("[TB] FAIL count_write_priority: got %0d expected %0d", rd, 100); end
      step(1'b0, 32'h0000_0000, 32'd0);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd101) begin errors++; $display("[TB] FAIL count_after_write: got %0d expected %0d", rd, 101); end
   endtask

   task automatic test_gpio_unmapped();
      logic [31:0] rd;
      logic [31:0] probe [5] = '{A_CTRL, A_COUNT, A_CMP, A_STATUS, 32'h0000_0010};
      step(1'b1, A_CTRL, 32'd0);
      gpio_in = 8'hA5;
      step(1'b0, 32'h0000_0000, 32'd0);
      busRead(A_GPIO_IN, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL gpio_in_latency1: got %h expected %h", rd, 32'd0); end
      step(1'b0, 32'h0000_0000, 32'd0);
      busRead(A_GPIO_IN, rd);
      checks++;
      if (rd !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL gpio_in_latency2: got %h expected %h", rd, 32'hA5); end
      step(1'b1, A_GPIO_OUT, 32'hFFFF_FF3C);
      busRead(A_GPIO_OUT, rd);
      checks++;
      if (gpio_out !== 8'h3C || rd !== 32'h0000_003C) begin
         errors++; $display("[TB] FAIL gpio_out_write: got pin=%h reg=%h expected 3c/0000003c", gpio_out, rd);
      end
      step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      step(1'b1, A_GPIO_IN, 32'h0000_0011);
      step(1'b1, A_RSVD, 32'hFFFF_FFFF);
      busRead(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected %h", rd, 32'd0); end
      busRead(A_RSVD, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reserved_read: got %h expected %h", rd, 32'd0); end
      busRead(A_GPIO_IN, rd);
      checks++;
      if (rd !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL gpio_in_readonly: got %h expected %h", rd, 32'hA5); end
      for (int i = 0; i < 5; i++) begin
         busRead(probe[i], rd);
         checks++;
         if (rd !== modelRead(probe[i])) begin
            errors++; $display("[TB] FAIL unmapped_no_side_effect @%h: got %h expected %h", probe[i], rd, modelRead(probe[i]));
         end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      step(1'b1, A_CTRL, 32'd0);
      step(1'b1, A_STATUS, 32'd1);
      step(1'b1, A_CMP, 32'd40);
      step(1'b1, A_COUNT, 32'd40);
      step(1'b1, A_CTRL, 32'b101);
      step(1'b0, 32'h0000_0000, 32'd0);
      step(1'b0, 32'h0000_0000, 32'd0);
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd42 || timer_irq !== 1'b1) begin
         errors++; $display("[TB] FAIL pre_reset_state: got count=%0d irq=%b expected 42/1", rd, timer_irq);
      end
      #3 reset = 1'b0;
      modelReset();
      busRead(A_COUNT, rd);
      checks++;
      if (rd !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_count: got %h expected %h", rd, 32'd0); end
      busRead(A_STATUS, rd);
      checks++;
      if (rd !== 32'd0 || gpio_out !== 8'd0 || timer_irq !== 1'b0) begin
         errors++; $display("[TB] FAIL async_reset_outputs: got status=%h gpio=%h irq=%b expected 0/00/0", rd, gpio_out, timer_irq);
      end
      busRead(32'h0000_0010, rd);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_survives_reset: got %h expected %h", rd, 32'hDEAD_BEEF); end
      @(posedge clk);
      #5 reset = 1'b1;
   endtask

   function automatic logic [31:0] pickAddr();
      int k;
      k = $urandom_range(0, 11);
      if (k <= 7) return 32'hFFFF_0000 + 32'(k * 4);
      if (k == 8) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (k == 9) return 32'h0000_1000;
      if (k == 10) return 32'hFFFF_0020;
      return 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
   endfunction

   task automatic test_random();
      logic [31:0] a, d, ra, rd;
      logic        we;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
         a  = pickAddr();
         we = ($urandom_range(0, 9) < 5);
         if (a == A_CTRL) d = 32'($urandom_range(0, 7));
         else if (a == A_COUNT || a == A_CMP) d = 32'($urandom_range(0, 12));
         else if (a == A_STATUS) d = 32'($urandom_range(0, 1));
         else d = $urandom;
         step(we, a, d);
         ra = pickAddr();
         busRead(ra, rd);
         if (modelKnown(ra)) begin
            checks++;
            if (rd !== modelRead(ra)) begin
               errors++; $display("[TB] FAIL random_read[%0d] @%h: got %h expected %h", i, ra, rd, modelRead(ra));
            end
         end
         checks++;
         if (gpio_out !== mGpioOut || timer_irq !== modelIrq()) begin
            errors++; $display("[TB] FAIL random_pins[%0d]: got gpio=%h irq=%b expected %h/%b", i, gpio_out, timer_irq, mGpioOut, modelIrq());
         end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_timer_autoreload();
      test_irq_w1c();
      test_wrap_priority();
      test_gpio_unmapped();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
